axi_lite_master_bridge: RTL

AXI_LITE_MASTER_BRIDGE -- requirements
Module: axi_lite_master_bridge

---
 rtl/axi_lite_pkg.sv | 18 +
 rtl/axi_lite_master_bridge.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: bridge FSM state encoding and response codes.
package axi_lite_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_WR_REQ,
      ST_WR_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   function automatic logic resp_is_err(input logic [1:0] resp);
      return resp != RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_master_bridge.sv
// CPU req/addr_ok/data_ok to AXI-Lite master, one transaction outstanding; zero-wait data_ok 3 cycles after addr_ok.
// New requests are held off (no addr_ok) while busy; every AXI valid is registered and held until its handshake.
module axi_lite_master_bridge
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  wr,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   output logic                  addr_ok,
   output logic                  data_ok,
   output logic [DATA_W-1:0]     rdata,
   output logic                  err,
   output logic [ADDR_W-1:0]     araddr,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_W-1:0]     rdata_m,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready,
   output logic [ADDR_W-1:0]     awaddr,
   output logic [2:0]            awprot,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [DATA_W-1:0]     wdata_m,
   output logic [DATA_W/8-1:0]   wstrb_m,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready
);

   state_t                state_q;
   logic                  data_ok_q;
   logic [DATA_W-1:0]     rdata_q;
   logic                  err_q;
   logic [ADDR_W-1:0]     araddr_q;
   logic [ADDR_W-1:0]     awaddr_q;
   logic                  arvalid_q;
   logic                  rready_q;
   logic                  awvalid_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W/8-1:0]   wstrb_q;
   logic                  wvalid_q;
   logic                  bready_q;
   logic                  accept;
   logic                  aw_done;
   logic                  w_done;

   // Blocking acceptance while data_ok is pending keeps completions and new grants in separate cycles.
   assign accept  = !reset && (state_q == ST_IDLE) && req && !data_ok_q;
   assign aw_done = !awvalid_q || awready;
   assign w_done  = !wvalid_q || wready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         data_ok_q <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         araddr_q  <= '0;
         awaddr_q  <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
      end else begin
         data_ok_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (wr) begin
                     awaddr_q  <= addr;
                     wdata_q   <= wdata;
                     wstrb_q   <= wstrb;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= ST_WR_REQ;
                  end else begin
                     araddr_q  <= addr;
                     arvalid_q <= 1'b1;
                     state_q   <= ST_RD_ADDR;
                  end
               end
            end
            ST_RD_ADDR: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (rvalid) begin
                  rready_q  <= 1'b0;
                  rdata_q   <= rdata_m;
                  err_q     <= resp_is_err(rresp);
                  data_ok_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            ST_WR_REQ: begin
               // AW and W retire independently; leave once both have been accepted.
               if (awready) awvalid_q <= 1'b0;
               if (wready)  wvalid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  bready_q <= 1'b1;
                  state_q  <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (bvalid) begin
                  bready_q  <= 1'b0;
                  err_q     <= resp_is_err(bresp);
                  data_ok_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign addr_ok = accept;
   assign data_ok = data_ok_q;
   assign rdata   = rdata_q;
   assign err     = err_q;
   assign araddr  = araddr_q;
   assign arprot  = 3'b000;
   assign arvalid = arvalid_q;
   assign rready  = rready_q;
   assign awaddr  = awaddr_q;
   assign awprot  = 3'b000;
   assign awvalid = awvalid_q;
   assign wdata_m = wdata_q;
   assign wstrb_m = wstrb_q;
   assign wvalid  = wvalid_q;
   assign bready  = bready_q;

endmodule
